// File: rtl/cache_addr_alloc_if.sv
// Purpose: bundles the allocator's bitmap-facing, pop-side and release-side signals.
// Latency: none, wiring only.
// Backpressure: pop side is valid/ready; bitmap and release sides have no backpressure.
// Modports: master = allocator (drives bitmap writes, alloc_*, pf_*);
//           slave  = environment (drives emp_ready_*, alloc_rdy, free_*).
// Optional: CACHE_ALLOC_DUP_CHECK_EN adds the sticky dup_err output.
interface cache_addr_alloc_if #(
  parameter int ADDR_W   = 10,
  parameter int PF_DEPTH = 4
);
  localparam int CNT_W = $clog2(PF_DEPTH) + 1;

  logic [ADDR_W-1:0] emp_ready_addr;
  logic              emp_ready_vld;
  logic              bm_wr_en_1;
  logic [ADDR_W-1:0] bm_wr_addr_1;
  logic              bm_wr_val_1;
  logic              bm_wr_en_2;
  logic [ADDR_W-1:0] bm_wr_addr_2;
  logic              bm_wr_val_2;
  logic              alloc_vld;
  logic [ADDR_W-1:0] alloc_addr;
  logic              alloc_rdy;
  logic              free_vld;
  logic [ADDR_W-1:0] free_addr;
  logic [CNT_W-1:0]  pf_count;
  logic              pf_empty;
`ifdef CACHE_ALLOC_DUP_CHECK_EN
  logic              dup_err;
`endif

  modport master (
    input  emp_ready_addr, emp_ready_vld, alloc_rdy, free_vld, free_addr,
`ifdef CACHE_ALLOC_DUP_CHECK_EN
    output dup_err,
`endif
    output bm_wr_en_1, bm_wr_addr_1, bm_wr_val_1,
    output bm_wr_en_2, bm_wr_addr_2, bm_wr_val_2,
    output alloc_vld, alloc_addr, pf_count, pf_empty
  );

  modport slave (
    output emp_ready_addr, emp_ready_vld, alloc_rdy, free_vld, free_addr,
`ifdef CACHE_ALLOC_DUP_CHECK_EN
    input  dup_err,
`endif
    input  bm_wr_en_1, bm_wr_addr_1, bm_wr_val_1,
    input  bm_wr_en_2, bm_wr_addr_2, bm_wr_val_2,
    input  alloc_vld, alloc_addr, pf_count, pf_empty
  );
endinterface

// File: rtl/cache_addr_alloc.sv
// Purpose: claims free addresses from the free-cell bitmap into a prefetch FIFO and returns released ones.
// Latency: claim/release bitmap writes 1 cycle after sampling; FIFO head visible 1 cycle after claim.
// Backpressure: claims stall while the FIFO is full (unless popped that cycle); releases are never stalled.
// Ports: clk, rst (synchronous, active-high); bus (cache_addr_alloc_if.master) carries
//   emp_ready_* from the bitmap, bm_wr_*_1 claim writes, bm_wr_*_2 release writes,
//   alloc_vld/alloc_addr/alloc_rdy pop handshake, free_vld/free_addr releases, pf_count/pf_empty.
// Optional: CACHE_ALLOC_DUP_CHECK_EN discards samples already held or in flight and sets sticky dup_err.
module cache_addr_alloc #(
  parameter int ADDR_W   = 10,
  parameter int PF_DEPTH = 4,
  parameter int BLACKOUT = 3
) (
  input logic             clk,
  input logic             rst,
  cache_addr_alloc_if.master bus
);
  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BLK_W = $clog2(BLACKOUT);

  typedef enum logic {SCAN, BLACK} state_t;

  state_t            state;
  logic [BLK_W-1:0]  blk_cnt;
  logic [ADDR_W-1:0] mem [PF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              claim_en, rel_en;
  logic [ADDR_W-1:0] claim_addr, rel_addr;

  logic pop, space, sample, claim;

  assign pop    = (count != '0) && bus.alloc_rdy;
  // A full FIFO still has room when its head leaves in the same cycle.
  assign space  = (count != CNT_W'(PF_DEPTH)) || pop;
  assign sample = (state == SCAN) && bus.emp_ready_vld && space;

`ifdef CACHE_ALLOC_DUP_CHECK_EN
  logic dup_hit, dup_err_q;

  // Compare against every occupied slot, walking from the head, plus the claim still in flight.
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < PF_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (mem[rd_ptr + PTR_W'(i)] == bus.emp_ready_addr))
        dup_hit = 1'b1;
    end
    if (claim_en && (claim_addr == bus.emp_ready_addr))
      dup_hit = 1'b1;
  end

  assign claim = sample && !dup_hit;

  // Only samples that would otherwise have been claimed are flagged.
  always_ff @(posedge clk) begin
    if (rst)
      dup_err_q <= 1'b0;
    else if (sample && dup_hit)
      dup_err_q <= 1'b1;
  end

  assign bus.dup_err = dup_err_q;
`else
  assign claim = sample;
`endif

  // Claim FSM, write ports and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SCAN;
      blk_cnt    <= '0;
      claim_en   <= 1'b0;
      claim_addr <= '0;
      rel_en     <= 1'b0;
      rel_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      claim_en   <= claim;
      claim_addr <= claim ? bus.emp_ready_addr : '0;
      rel_en     <= bus.free_vld;
      rel_addr   <= bus.free_vld ? bus.free_addr : '0;

      // The bitmap needs BLACKOUT cycles after a claim before its first-free output
      // reflects the write, so its output is ignored for that long.
      unique case (state)
        SCAN: begin
          if (claim) begin
            state   <= BLACK;
            blk_cnt <= BLK_W'(BLACKOUT - 1);
          end
        end
        BLACK: begin
          if (blk_cnt == '0)
            state <= SCAN;
          else
            blk_cnt <= blk_cnt - BLK_W'(1);
        end
        default: state <= SCAN;
      endcase

      if (claim) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({claim, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (claim)
      mem[wr_ptr] <= bus.emp_ready_addr;
  end

  assign bus.bm_wr_en_1   = claim_en;
  assign bus.bm_wr_addr_1 = claim_addr;
  assign bus.bm_wr_val_1  = ~rst;
  assign bus.bm_wr_en_2   = rel_en;
  assign bus.bm_wr_addr_2 = rel_addr;
  assign bus.bm_wr_val_2  = 1'b0;
  assign bus.alloc_vld    = (count != '0);
  assign bus.alloc_addr   = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.pf_count     = count;
  // Follows occupancy, so it reads 1 while the FIFO is held empty.
  assign bus.pf_empty     = (count == '0);
endmodule

// File: tb/tb_cache_addr_alloc.sv
// Purpose: self-checking bench for cache_addr_alloc: directed vector table, corner sequences, random run vs model.
// Latency: checks sample outputs on the falling edge after each rising edge.
// Backpressure: alloc_rdy and emp_ready_vld are driven from the table and randomly.
module tb_cache_addr_alloc;
  localparam int A  = 10;
  localparam int P  = 4;
  localparam int BO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_addr_alloc_if #(.ADDR_W(A), .PF_DEPTH(P)) bus ();
  cache_addr_alloc #(.ADDR_W(A), .PF_DEPTH(P), .BLACKOUT(BO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of claimed addresses and the earliest edge at which
  // the bitmap may be sampled again.
  logic [A-1:0] q[$];
  int           cyc = 0;
  int           next_ok = 0;
  logic         m_en1 = 0, m_en2 = 0, m_dup = 0;
  logic [A-1:0] m_a1 = 0, m_a2 = 0;

  task automatic model_step();
    logic pop, samp, hit;
    if (rst) begin
      q.delete();
      m_en1 = 0; m_a1 = 0; m_en2 = 0; m_a2 = 0; m_dup = 0;
      next_ok = cyc + 1;
    end else begin
      pop  = (q.size() != 0) && bus.alloc_rdy;
      samp = bus.emp_ready_vld && (cyc >= next_ok) && ((q.size() < P) || pop);
`ifdef CACHE_ALLOC_DUP_CHECK_EN
      if (samp) begin
        hit = m_en1 && (m_a1 == bus.emp_ready_addr);
        foreach (q[i]) if (q[i] == bus.emp_ready_addr) hit = 1'b1;
        if (hit) begin
          m_dup = 1'b1;
          samp  = 1'b0;
        end
      end
`else
      hit = 1'b0;
`endif
      m_en1 = samp;
      m_a1  = samp ? bus.emp_ready_addr : '0;
      m_en2 = bus.free_vld;
      m_a2  = bus.free_vld ? bus.free_addr : '0;
      if (pop) void'(q.pop_front());
      if (samp) begin
        q.push_back(bus.emp_ready_addr);
        next_ok = cyc + 1 + BO;
      end
    end
    cyc++;
  endtask

  task automatic compare_model();
    chk("m_en1",   bus.bm_wr_en_1,   m_en1);
    chk("m_a1",    bus.bm_wr_addr_1, m_a1);
    chk("m_val1",  bus.bm_wr_val_1,  !rst);
    chk("m_en2",   bus.bm_wr_en_2,   m_en2);
    chk("m_a2",    bus.bm_wr_addr_2, m_a2);
    chk("m_val2",  bus.bm_wr_val_2,  1'b0);
    chk("m_cnt",   bus.pf_count,     q.size());
    chk("m_empty", bus.pf_empty,     q.size() == 0);
    chk("m_vld",   bus.alloc_vld,    q.size() != 0);
    chk("m_head",  bus.alloc_addr,   (q.size() != 0) ? q[0] : '0);
`ifdef CACHE_ALLOC_DUP_CHECK_EN
    chk("m_dup",   bus.dup_err,      m_dup);
`endif
  endtask

  task automatic drive(input logic r, input logic ev, input logic [A-1:0] ea,
                       input logic ar, input logic fv, input logic [A-1:0] fa);
    rst                = r;
    bus.emp_ready_vld  = ev;
    bus.emp_ready_addr = ea;
    bus.alloc_rdy      = ar;
    bus.free_vld       = fv;
    bus.free_addr      = fa;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic r, ev; logic [A-1:0] ea; logic ar, fv; logic [A-1:0] fa;
    logic en1; logic [A-1:0] a1; int cnt; logic vld; logic [A-1:0] head;
    logic en2; logic [A-1:0] a2;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic r, input logic ev, input logic [A-1:0] ea,
                     input logic ar, input logic fv, input logic [A-1:0] fa,
                     input logic en1, input logic [A-1:0] a1, input int cnt,
                     input logic vld, input logic [A-1:0] head,
                     input logic en2, input logic [A-1:0] a2);
    vec_t v;
    v = '{r, ev, ea, ar, fv, fa, en1, a1, cnt, vld, head, en2, a2};
    tv.push_back(v);
  endtask

  initial begin
    bus.emp_ready_vld = 0; bus.emp_ready_addr = 0; bus.alloc_rdy = 0;
    bus.free_vld = 0; bus.free_addr = 0;

    //   r ev ea     ar fv fa      en1 a1    cnt vld head   en2 a2
    add(1, 0, 0,     0, 0, 0,      0, 0,     0, 0, 0,      0, 0);
    add(1, 0, 0,     0, 0, 0,      0, 0,     0, 0, 0,      0, 0);
    // Address 0 held: claimed at once, then three ignored cycles.
    add(0, 1, 0,     0, 0, 0,      1, 0,     1, 1, 0,      0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 1, 0,   0, 0, 0,      0, 0,     1, 1, 0,      0, 0);
    // Bitmap advances 1, 2, 3 with a 4-cycle claim period.
    for (int k = 1; k <= 3; k++) begin
      add(0, 1, A'(k), 0, 0, 0,    1, A'(k), k + 1, 1, 0,  0, 0);
      for (int i = 0; i < 3; i++)
        add(0, 1, A'(k + 1), 0, 0, 0, 0, 0,  k + 1, 1, 0,  0, 0);
    end
    // FIFO full: address 4 is not claimed.
    add(0, 1, 4,     0, 0, 0,      0, 0,     4, 1, 0,      0, 0);
    // Pop 0 and push 4 in the same cycle.
    add(0, 1, 4,     1, 0, 0,      1, 4,     4, 1, 1,      0, 0);
    // Back-to-back releases of 0x155.
    add(0, 0, 0,     0, 1, 10'h155, 0, 0,    4, 1, 1,      1, 10'h155);
    add(0, 0, 0,     0, 1, 10'h155, 0, 0,    4, 1, 1,      1, 10'h155);
    add(0, 0, 0,     1, 0, 0,      0, 0,     3, 1, 2,      0, 0);
    add(0, 0, 0,     1, 0, 0,      0, 0,     2, 1, 3,      0, 0);
    // Claim 5 while popping 3, leaving 2 entries in BLACK; then reset mid-blackout.
    add(0, 1, 5,     1, 0, 0,      1, 5,     2, 1, 4,      0, 0);
    add(1, 0, 0,     0, 0, 0,      0, 0,     0, 0, 0,      0, 0);
    add(0, 0, 0,     0, 0, 0,      0, 0,     0, 0, 0,      0, 0);
    // Back in SCAN: immediate claim.
    add(0, 1, 6,     0, 0, 0,      1, 6,     1, 1, 6,      0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].r, tv[i].ev, tv[i].ea, tv[i].ar, tv[i].fv, tv[i].fa);
      chk($sformatf("v%0d_en1", i),  bus.bm_wr_en_1,   tv[i].en1);
      chk($sformatf("v%0d_a1", i),   bus.bm_wr_addr_1, tv[i].a1);
      chk($sformatf("v%0d_cnt", i),  bus.pf_count,     tv[i].cnt);
      chk($sformatf("v%0d_vld", i),  bus.alloc_vld,    tv[i].vld);
      chk($sformatf("v%0d_head", i), bus.alloc_addr,   tv[i].head);
      chk($sformatf("v%0d_en2", i),  bus.bm_wr_en_2,   tv[i].en2);
      chk($sformatf("v%0d_a2", i),   bus.bm_wr_addr_2, tv[i].a2);
    end

`ifdef CACHE_ALLOC_DUP_CHECK_EN
    // Stale bitmap re-presents 0x007 already held in the FIFO.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 0, 0);
    chk("dup_first_claim", bus.bm_wr_en_1, 1'b1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 7, 0, 0, 0);
    chk("dup_no_claim", bus.bm_wr_en_1, 1'b0);
    chk("dup_cnt", bus.pf_count, 1);
    chk("dup_set", bus.dup_err, 1'b1);
    drive(0, 1, 8, 0, 0, 0);
    chk("dup_next_claim", bus.bm_wr_addr_1, 8);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      chk("dup_sticky", bus.dup_err, 1'b1);
    end
    drive(1, 0, 0, 0, 0, 0);
    chk("dup_cleared", bus.dup_err, 1'b0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [A-1:0] ea, fa;
`ifdef CACHE_ALLOC_DUP_CHECK_EN
      ea = A'($urandom_range(0, 15));
`else
      ea = A'($urandom_range(0, (1 << A) - 1));
`endif
      fa = A'($urandom_range(0, (1 << A) - 1));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ea,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0), fa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
